// File: rtl/fifo_rr_drain.sv
`default_nettype none
// fifo_rr_drain: round-robin scheduler that drains N show-ahead FIFOs onto one
// registered valid/ready stream, popping at most BURST_MAX words per grant.
module fifo_rr_drain #(
  parameter int N_QUEUES  = 4,
  parameter int DWIDTH    = 64,
  parameter int BURST_MAX = 4,
  parameter int QWIDTH    = $clog2(N_QUEUES)
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic [N_QUEUES-1:0]        en_i,
  input  logic [N_QUEUES-1:0]        empty_i,
  input  logic [N_QUEUES*DWIDTH-1:0] q_i,
  output logic [N_QUEUES-1:0]        rdreq_o,
  output logic [DWIDTH-1:0]          data_o,
  output logic [QWIDTH-1:0]          qid_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [QWIDTH-1:0]          grant_o,
  output logic                       busy_o
);

  localparam int                CWIDTH     = $clog2(BURST_MAX + 1);
  localparam logic [CWIDTH-1:0] LAST_BEAT  = CWIDTH'(BURST_MAX - 1);
  localparam logic [QWIDTH-1:0] LAST_RST   = QWIDTH'(N_QUEUES - 1);
  localparam logic [QWIDTH:0]   NQ_WIDE    = (QWIDTH+1)'(N_QUEUES);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [QWIDTH-1:0]   grant_q, grant_d;
  logic [QWIDTH-1:0]   last_q, last_d;
  logic [CWIDTH-1:0]   burst_q, burst_d;
  logic                valid_q, valid_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic [QWIDTH-1:0]   qid_q, qid_d;

  logic [N_QUEUES-1:0] elig;
  logic [N_QUEUES-1:0] rd_strobe;
  logic                pop;
  logic                arb_found;
  logic [QWIDTH-1:0]   arb_idx;
  logic [QWIDTH:0]     cand;
  logic [DWIDTH-1:0]   q_arr [N_QUEUES];

  assign elig = en_i & ~empty_i;

  for (genvar k = 0; k < N_QUEUES; k++) begin : g_unpack
    assign q_arr[k] = q_i[k*DWIDTH +: DWIDTH];
  end

  // Cyclic search starting just after the last served queue.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_QUEUES; i++) begin
      cand = {1'b0, last_q} + (QWIDTH+1)'(i);
      if (cand >= NQ_WIDE) begin
        cand = cand - NQ_WIDE;
      end
      if (!arb_found && elig[cand[QWIDTH-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[QWIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    burst_d   = burst_q;
    valid_d   = valid_q;
    data_d    = data_q;
    qid_d     = qid_q;
    pop       = 1'b0;
    rd_strobe = '0;

    case (state_q)
      ST_ARB: begin
        if (arb_found) begin
          grant_d = arb_idx;
          burst_d = '0;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        pop = elig[grant_q] & (~valid_q | ready_i);
        if (pop) begin
          rd_strobe[grant_q] = 1'b1;
          burst_d            = burst_q + CWIDTH'(1);
        end
        // A stalled but still eligible queue keeps the grant.
        if ((pop && (burst_q == LAST_BEAT)) || !elig[grant_q]) begin
          state_d = ST_ARB;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_ARB;
    endcase

    if (pop) begin
      data_d  = q_arr[grant_q];
      qid_d   = grant_q;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= ST_ARB;
      grant_q <= '0;
      last_q  <= LAST_RST;
      burst_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      qid_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      qid_q   <= qid_d;
    end
  end

  assign rdreq_o = srst_i ? '0 : rd_strobe;
  assign data_o  = data_q;
  assign qid_o   = qid_q;
  assign valid_o = valid_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q == ST_SERVE);

endmodule
`default_nettype wire
